// File: rtl/apb_table_target_if.sv
// APB bus bundle between the subsystem decoder (master) and an apb_table_target leaf (slave).
interface apb_table_target_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_table_target.sv
// APB leaf target: ID/STATUS/ERR_COUNT words, a bank of RW control registers and a
// word-addressed table behind a fixed-latency read port. Registers respond with zero waits.
module apb_table_target #(
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_RW      = 4,
  parameter logic [ADDR_W-1:0] MEM_BASE    = 12'h400,
  parameter int unsigned       MEM_DEPTH   = 256,
  parameter int unsigned       MEM_LATENCY = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'h1b45f720,
  parameter logic [DATA_W-1:0] RW_RESET    = '0,
  localparam int unsigned      MEM_AW      = $clog2(MEM_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  apb_table_target_if.slave        apb,
  input  logic [DATA_W-1:0]        status_in,
  output logic [NUM_RW*DATA_W-1:0] rw_q,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int unsigned       WORD_W   = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] MEM_MASK = ~ADDR_W'(MEM_DEPTH * 4 - 1);
  localparam logic [2:0]        LAT      = 3'(MEM_LATENCY);
  localparam logic [WORD_W-1:0] W_ID     = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_ERR    = WORD_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG_RESP,
    S_MEM_ISSUE,
    S_MEM_WAIT,
    S_MEM_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_W-1:0]         prdata_q, prdata_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]         mem_wdata_q, mem_wdata_d;
  logic [15:0]               err_cnt_q, err_cnt_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [WORD_W-1:0]         req_word_q, req_word_d;
  logic                      req_write_q, req_write_d;
  logic [DATA_W-1:0]         req_wdata_q, req_wdata_d;
  logic                      req_err_q, req_err_d;
  logic [NUM_RW*DATA_W-1:0]  rw_d;

  logic [WORD_W-1:0] word;
  logic              hit_mem;
  logic              hit_rw;
  logic              hit_reg;
  logic              bad;
  logic [DATA_W-1:0] rd_val;

  // Setup-phase decode of the live bus address.
  always_comb begin
    word    = apb.paddr[ADDR_W-1:2];
    hit_mem = (apb.paddr & MEM_MASK) == MEM_BASE;
    hit_rw  = 1'b0;
    rd_val  = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (word == WORD_W'(4 + i)) begin
        hit_rw = 1'b1;
        rd_val = rw_q[i*DATA_W +: DATA_W];
      end
    end
    if (word == W_ID)     rd_val = ID_VALUE;
    if (word == W_STATUS) rd_val = status_in;
    if (word == W_ERR)    rd_val = DATA_W'(err_cnt_q);
    hit_reg = (word == W_ID) || (word == W_STATUS) || (word == W_ERR) || hit_rw;
    bad     = (apb.paddr[1:0] != 2'b00)
           || (!hit_mem && apb.pwrite && ((word == W_ID) || (word == W_STATUS)))
           || !(hit_reg || hit_mem);
  end

  always_comb begin
    state_d     = state_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    req_word_d  = req_word_q;
    req_write_d = req_write_q;
    req_wdata_d = req_wdata_q;
    req_err_d   = req_err_q;
    rw_d        = rw_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (apb.psel && !apb.penable) begin
          req_word_d  = word;
          req_write_d = apb.pwrite;
          req_wdata_d = apb.pwdata;
          req_err_d   = bad;
          if (bad) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = S_REG_RESP;
          end else if (hit_mem) begin
            mem_req_d  = 1'b1;
            mem_we_d   = apb.pwrite;
            mem_addr_d = apb.paddr[MEM_AW+1:2];
            if (apb.pwrite) begin
              mem_wdata_d = apb.pwdata;
              pready_d    = 1'b1;
            end
            state_d = S_MEM_ISSUE;
          end else begin
            pready_d = 1'b1;
            if (!apb.pwrite) prdata_d = rd_val;
            state_d = S_REG_RESP;
          end
        end
      end
      // Side effects commit at the pready edge so a reset during the response drops them.
      S_REG_RESP: begin
        if (req_err_q) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end else if (req_write_q) begin
          if (req_word_q == W_ERR) err_cnt_d = '0;
          for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (req_word_q == WORD_W'(4 + i)) rw_d[i*DATA_W +: DATA_W] = req_wdata_q;
          end
        end
        state_d = S_IDLE;
      end
      S_MEM_ISSUE: begin
        cnt_d   = 3'd1;
        state_d = req_write_q ? S_IDLE : S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (cnt_q == LAT) begin
          prdata_d = mem_rdata;
          pready_d = 1'b1;
          state_d  = S_MEM_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_MEM_RESP: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_cnt_q   <= '0;
      cnt_q       <= '0;
      req_word_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      req_err_q   <= 1'b0;
      rw_q        <= {NUM_RW{RW_RESET}};
    end else begin
      state_q     <= state_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_cnt_q   <= err_cnt_d;
      cnt_q       <= cnt_d;
      req_word_q  <= req_word_d;
      req_write_q <= req_write_d;
      req_wdata_q <= req_wdata_d;
      req_err_q   <= req_err_d;
      rw_q        <= rw_d;
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_apb_table_target.sv
// Bench for apb_table_target (MEM_LATENCY=3): directed and random APB traffic against a
// behavioural address-map model, with a latency-accurate table memory attached.
module tb_apb_table_target;
  localparam int          LAT = 3;
  localparam logic [31:0] ID  = 32'h1b45f720;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_table_target_if #(.ADDR_W(12), .DATA_W(32)) apb ();

  logic [31:0]  status_in;
  logic [127:0] rw_q;
  logic         mem_req, mem_we;
  logic [7:0]   mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;

  apb_table_target #(
    .ADDR_W(12), .DATA_W(32), .NUM_RW(4), .MEM_BASE(12'h400), .MEM_DEPTH(256),
    .MEM_LATENCY(LAT), .ID_VALUE(ID), .RW_RESET(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .apb(apb), .status_in(status_in), .rw_q(rw_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h0101_0107) ^ 32'h5A5A_0000;
  endfunction

  // Table memory: data for a read request appears LAT cycles after the mem_req cycle.
  logic [31:0]  mem_s [256];
  logic [255:0] wr_s = '0;
  logic [31:0]  pipe [LAT];
  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      mem_s[mem_addr] <= mem_wdata;
      wr_s[mem_addr]  <= 1'b1;
    end
    pipe[0] <= (mem_req && !mem_we) ? (wr_s[mem_addr] ? mem_s[mem_addr] : init_word(int'(mem_addr)))
                                    : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rw [4];
  logic [31:0] m_mem [256];
  int          m_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                       output logic [31:0] erd, output bit eerr, output int ewaits, output bit emem);
    int idx;
    erd = '0; eerr = 1'b0; ewaits = 0; emem = 1'b0;
    if (a[1:0] != 2'b00) eerr = 1'b1;
    else if (a >= 12'h400 && a < 12'h800) begin
      emem = 1'b1;
      idx  = (int'(a) - 'h400) / 4;
      if (wr) m_mem[idx] = wd;
      else begin erd = m_mem[idx]; ewaits = LAT + 1; end
    end else if (a == 12'h000) begin
      if (wr) eerr = 1'b1; else erd = ID;
    end else if (a == 12'h004) begin
      if (wr) eerr = 1'b1; else erd = status_in;
    end else if (a == 12'h008) begin
      if (wr) m_err = 0; else erd = 32'(m_err);
    end else if (a >= 12'h010 && a < 12'h020) begin
      idx = (int'(a) - 'h10) / 4;
      if (wr) m_rw[idx] = wd; else erd = m_rw[idx];
    end else eerr = 1'b1;
    if (eerr && m_err < 65535) m_err++;
  endtask

  // Entered and left at #1 into a free cycle; that cycle becomes the setup phase.
  task automatic access(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                        output logic [31:0] rd);
    logic [31:0] erd;
    bit          eerr, emem;
    int          ewaits, waits;
    chk("pready_idle", apb.pready, 1'b0);
    chk("rw_q", rw_q, {m_rw[3], m_rw[2], m_rw[1], m_rw[0]});
    model(a, wr, wd, erd, eerr, ewaits, emem);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.paddr = a; apb.pwrite = wr; apb.pwdata = wd;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    chk("mem_req_t1", mem_req, emem);
    waits = 0;
    while (!apb.pready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("wait_states", 32'(waits), 32'(ewaits));
    chk("pslverr", apb.pslverr, eerr);
    if (!wr || eerr) chk("prdata", apb.prdata, erd);
    rd = apb.prdata;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [11:0] a;
    logic [11:0] unm [5];
    bit          wr;
    int          kind, w;
    unm = '{12'h00C, 12'h020, 12'h3FC, 12'h800, 12'hFFC};

    for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
    for (int i = 0; i < 4; i++) m_rw[i] = '0;
    m_err = 0;
    rst = 1'b1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    status_in = 32'hA5A5_0001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", apb.pready, 1'b0);
    chk("rst_prdata", apb.prdata, 32'h0);
    chk("rst_pslverr", apb.pslverr, 1'b0);
    chk("rst_mem_req", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    chk("rst_rw_q", rw_q, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    access(12'h000, 1'b0, 32'h0, rd);
    chk("id_const", rd, 32'h1b45f720);
    access(12'h004, 1'b0, 32'h0, rd);
    chk("status_const", rd, 32'hA5A5_0001);

    access(12'h014, 1'b1, 32'hDEAD_BEEF, rd);
    access(12'h014, 1'b0, 32'h0, rd);
    chk("rw1_readback", rd, 32'hDEAD_BEEF);
    chk("rw1_port", rw_q[63:32], 32'hDEAD_BEEF);
    chk("rw_others", {rw_q[127:64], rw_q[31:0]}, 96'h0);

    access(12'h414, 1'b1, 32'h1234_5678, rd);
    access(12'h414, 1'b0, 32'h0, rd);
    chk("table_readback", rd, 32'h1234_5678);

    access(12'h00C, 1'b0, 32'h0, rd);
    access(12'h000, 1'b1, 32'h1111_1111, rd);
    access(12'h402, 1'b0, 32'h0, rd);
    access(12'h008, 1'b0, 32'h0, rd);
    chk("err_count3", rd, 32'd3);
    access(12'h008, 1'b1, 32'hFFFF_FFFF, rd);
    access(12'h008, 1'b0, 32'h0, rd);
    chk("err_cleared", rd, 32'd0);

    dut.err_cnt_q = 16'hFFFE;
    m_err = 'hFFFE;
    for (int i = 0; i < 3; i++) access(12'h0FC, 1'b0, 32'h0, rd);
    access(12'h008, 1'b0, 32'h0, rd);
    chk("err_saturate", rd, 32'h0000_FFFF);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 10);
      status_in = $urandom;
      wr = 1'b0;
      a  = 12'h000;
      w  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 255);
      case (kind)
        0: a = 12'h000;
        1: a = 12'h004;
        2: a = 12'h008;
        3: begin a = 12'h008; wr = ($urandom_range(0, 3) == 0); end
        4: begin a = 12'h010 + 12'($urandom_range(0, 3) * 4); wr = 1'b1; end
        5: a = 12'h010 + 12'($urandom_range(0, 3) * 4);
        6: begin a = 12'h400 + 12'(w * 4); wr = 1'b1; end
        7: a = 12'h400 + 12'(w * 4);
        8: begin
          a = 12'($urandom_range(0, 4095));
          if (a[1:0] == 2'b00) a[0] = 1'b1;
          wr = $urandom_range(0, 1) == 1;
        end
        9: begin a = unm[$urandom_range(0, 4)]; wr = $urandom_range(0, 1) == 1; end
        default: begin a = ($urandom_range(0, 1) == 1) ? 12'h000 : 12'h004; wr = 1'b1; end
      endcase
      access(a, wr, $urandom, rd);
    end

    access(12'h018, 1'b1, 32'hCAFE_0042, rd);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.paddr = 12'h414; apb.pwrite = 1'b0;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    chk("rstwait_mem_req", mem_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstwait_pready", apb.pready, 1'b0);
    chk("rstwait_prdata", apb.prdata, 32'h0);
    chk("rstwait_mem", {mem_req, mem_addr}, 9'h0);
    chk("rstwait_rw_q", rw_q, 128'h0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    for (int i = 0; i < 4; i++) m_rw[i] = '0;
    m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    access(12'h414, 1'b0, 32'h0, rd);
    access(12'h008, 1'b0, 32'h0, rd);
    access(12'h018, 1'b0, 32'h0, rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
